// File: rtl/fods_pkg.sv
// Shared constants and width helpers for the first-order sigma-delta link.
package fods_pkg;

  // Number of integrator / comb sections in the CIC decimator.
  localparam int unsigned FODS_CIC_ORDER = 3;

  // Decimated results dropped after reset while the CIC fills.
  localparam int unsigned FODS_SETTLE_DISCARD = 2;

  // Internal CIC width: enough for a full-scale sinc3 gain of 2^(3*D) plus one bit.
  function automatic int unsigned fods_cw(input int unsigned decim_log2);
    return FODS_CIC_ORDER * decim_log2 + 1;
  endfunction

  // Right shift that maps the CIC gain onto a DATA_W-bit unsigned sample.
  function automatic int unsigned fods_shift(input int unsigned decim_log2,
                                             input int unsigned data_w);
    return FODS_CIC_ORDER * decim_log2 - data_w;
  endfunction

endpackage

// File: rtl/fods_cic_comb_stage.sv
// One CIC comb section: registered first difference at the decimated rate.
module fods_cic_comb_stage #(
  parameter int unsigned CW = 19
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [CW-1:0] i_data,
  output logic [CW-1:0] o_data,
  output logic          o_valid
);

  logic [CW-1:0] r_prev;
  logic [CW-1:0] r_diff;
  logic          r_valid;

  // Difference against the previous decimated input; modulo-2^CW wrap is intended.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev  <= '0;
      r_diff  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_en;
      if (i_en) begin
        r_diff <= i_data - r_prev;
        r_prev <= i_data;
      end
    end
  end

  assign o_data  = r_diff;
  assign o_valid = r_valid;

endmodule

// File: rtl/fods_cic_demod.sv
// Sigma-delta receive path: sinc3 CIC decimator, scaling/saturation and a
// one-entry valid/ready output register with overrun indication.
module fods_cic_demod
  import fods_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DECIM_LOG2 = 6
) (
  input  logic              demod_clk,
  input  logic              demod_rst,
  input  logic              demod_din,
  input  logic              demod_din_en,
  output logic [DATA_W-1:0] demod_dout,
  output logic              demod_valid,
  input  logic              demod_ready,
  output logic              demod_overrun
);

  localparam int unsigned CW    = fods_cw(DECIM_LOG2);
  localparam int unsigned SHIFT = fods_shift(DECIM_LOG2, DATA_W);
  localparam logic [1:0]  SETTLE_N = 2'(FODS_SETTLE_DISCARD);

  // Integrator chain.
  logic [CW-1:0] r_i1, r_i2, r_i3;
  logic [CW-1:0] w_i1_nx, w_i2_nx, w_i3_nx;

  // Decimation.
  logic [DECIM_LOG2-1:0] r_cnt;
  logic                  r_tick;

  // Comb pipeline.
  logic [CW-1:0] w_c1, w_c2, w_c3;
  logic          w_v1, w_v2, w_v3;

  // Scaling and output.
  logic [CW-1:0]     w_scaled;
  logic              w_sat;
  logic [DATA_W-1:0] w_sample;
  logic              w_present;
  logic [1:0]        r_settle;
  logic [DATA_W-1:0] r_dout, w_dout_nx;
  logic              r_valid, w_valid_nx;
  logic              r_overrun, w_overrun_nx;

  // Chained same-edge integrator update so I3 reflects the bit consumed this cycle.
  always_comb begin
    w_i1_nx = r_i1 + {{(CW-1){1'b0}}, demod_din};
    w_i2_nx = r_i2 + w_i1_nx;
    w_i3_nx = r_i3 + w_i2_nx;
  end

  // Integrators advance only on qualified input bits.
  always_ff @(posedge demod_clk) begin
    if (demod_rst) begin
      r_i1 <= '0;
      r_i2 <= '0;
      r_i3 <= '0;
    end else if (demod_din_en) begin
      r_i1 <= w_i1_nx;
      r_i2 <= w_i2_nx;
      r_i3 <= w_i3_nx;
    end
  end

  // Decimation counter; tick is registered on the edge that consumes the last bit of a period.
  always_ff @(posedge demod_clk) begin
    if (demod_rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= demod_din_en & (&r_cnt);
      if (demod_din_en) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  fods_cic_comb_stage #(
    .CW (CW)
  ) u_comb1 (
    .i_clk   (demod_clk),
    .i_rst   (demod_rst),
    .i_en    (r_tick),
    .i_data  (r_i3),
    .o_data  (w_c1),
    .o_valid (w_v1)
  );

  fods_cic_comb_stage #(
    .CW (CW)
  ) u_comb2 (
    .i_clk   (demod_clk),
    .i_rst   (demod_rst),
    .i_en    (w_v1),
    .i_data  (w_c1),
    .o_data  (w_c2),
    .o_valid (w_v2)
  );

  fods_cic_comb_stage #(
    .CW (CW)
  ) u_comb3 (
    .i_clk   (demod_clk),
    .i_rst   (demod_rst),
    .i_en    (w_v2),
    .i_data  (w_c2),
    .o_data  (w_c3),
    .o_valid (w_v3)
  );

  // Scale CIC gain down to DATA_W bits; only an all-ones input can reach 2^DATA_W.
  always_comb begin
    w_scaled = w_c3 >> SHIFT;
    w_sat    = |w_scaled[CW-1:DATA_W];
    w_sample = w_sat ? {DATA_W{1'b1}} : w_scaled[DATA_W-1:0];
  end

  assign w_present = w_v3 & (r_settle == SETTLE_N);

  // Count discarded results until the CIC history is fully populated.
  always_ff @(posedge demod_clk) begin
    if (demod_rst) begin
      r_settle <= '0;
    end else if (w_v3 && (r_settle != SETTLE_N)) begin
      r_settle <= r_settle + 1'b1;
    end
  end

  // Output register next state: a new sample always wins; overwriting an unaccepted one flags overrun.
  always_comb begin
    w_dout_nx    = r_dout;
    w_valid_nx   = r_valid;
    w_overrun_nx = 1'b0;
    if (w_present) begin
      w_dout_nx    = w_sample;
      w_valid_nx   = 1'b1;
      w_overrun_nx = r_valid & ~demod_ready;
    end else if (r_valid && demod_ready) begin
      w_valid_nx = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge demod_clk) begin
    if (demod_rst) begin
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_dout    <= w_dout_nx;
      r_valid   <= w_valid_nx;
      r_overrun <= w_overrun_nx;
    end
  end

  assign demod_dout    = r_dout;
  assign demod_valid   = r_valid;
  assign demod_overrun = r_overrun;

endmodule

// File: tb/tb_fods_cic_demod.sv
// Directed bench for fods_cic_demod: default 16-bit/64x instance plus a 3-bit/2x instance.
module tb_fods_cic_demod;

  logic        clk;
  logic        rst;
  logic        din;
  logic        din_en;
  logic        ready;
  logic [15:0] dout;
  logic        valid;
  logic        overrun;
  logic [2:0]  s_dout;
  logic        s_valid;
  logic        s_overrun;

  int checks;
  int errors;

  fods_cic_demod #(
    .DATA_W     (16),
    .DECIM_LOG2 (6)
  ) u_dut (
    .demod_clk     (clk),
    .demod_rst     (rst),
    .demod_din     (din),
    .demod_din_en  (din_en),
    .demod_dout    (dout),
    .demod_valid   (valid),
    .demod_ready   (ready),
    .demod_overrun (overrun)
  );

  fods_cic_demod #(
    .DATA_W     (3),
    .DECIM_LOG2 (1)
  ) u_small (
    .demod_clk     (clk),
    .demod_rst     (rst),
    .demod_din     (din),
    .demod_din_en  (din_en),
    .demod_dout    (s_dout),
    .demod_valid   (s_valid),
    .demod_ready   (ready),
    .demod_overrun (s_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, let one rising edge consume them, then settle before sampling.
  task automatic tick(input logic b, input logic e);
    din    = b;
    din_en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    checks++;
    if (valid !== 1'b0 || dout !== 16'h0000 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h o=%b want v=0 d=0000 o=0", valid, dout, overrun);
    end
    checks++;
    if (s_valid !== 1'b0 || s_dout !== 3'd0) begin
      errors++;
      $display("FAIL reset_small got v=%b d=%h want v=0 d=0", s_valid, s_dout);
    end
    rst = 1'b0;
  endtask

  // Constant-input first-order modulator feeding the decimator continuously.
  task automatic test_loopback(input logic [15:0] x);
    logic [15:0] acc;
    logic [16:0] sum;
    int          n_out;
    int          last;
    do_reset();
    ready = 1'b1;
    acc   = '0;
    n_out = 0;
    last  = 0;
    for (int i = 0; i < 326; i++) begin
      if (i < 320) begin
        sum = {1'b0, acc} + {1'b0, x};
        acc = sum[15:0];
        tick(sum[16], 1'b1);
      end else begin
        tick(1'b0, 1'b0);
      end
      if (valid === 1'b1) begin
        n_out++;
        checks++;
        if (dout !== x) begin
          errors++;
          $display("FAIL loopback_value x=%h out#%0d got %h want %h", x, n_out, dout, x);
        end
        checks++;
        if ((n_out == 1 && i != 195) || (n_out > 1 && i - last != 64)) begin
          errors++;
          $display("FAIL loopback_timing x=%h out#%0d got cycle %0d prev %0d", x, n_out, i, last);
        end
        last = i;
      end
    end
    checks++;
    if (n_out != 3) begin
      errors++;
      $display("FAIL loopback_count x=%h got %0d want 3", x, n_out);
    end
  endtask

  // Ones then zeros: saturated 0xFFFF, then the sinc3 step-down tail to 0.
  task automatic test_full_scale();
    logic [15:0] exp_v [4];
    int          n_out;
    int          first;
    exp_v[0] = 16'hFFFF;
    exp_v[1] = 16'hD350;
    exp_v[2] = 16'h28B0;
    exp_v[3] = 16'h0000;
    do_reset();
    ready = 1'b1;
    n_out = 0;
    first = -1;
    for (int i = 0; i < 390; i++) begin
      tick(i < 192, i < 384);
      if (valid === 1'b1) begin
        if (first < 0) first = i;
        if (n_out < 4) begin
          checks++;
          if (dout !== exp_v[n_out]) begin
            errors++;
            $display("FAIL full_scale_value out#%0d got %h want %h", n_out + 1, dout, exp_v[n_out]);
          end
        end
        n_out++;
      end
    end
    checks++;
    if (first != 195) begin
      errors++;
      $display("FAIL full_scale_latency got cycle %0d want 195", first);
    end
    checks++;
    if (n_out != 4) begin
      errors++;
      $display("FAIL full_scale_count got %0d want 4", n_out);
    end
  endtask

  // Alternating enabled bits with din_en pattern 1,0,0.
  task automatic test_enable_gaps();
    logic nb;
    int   n_out;
    int   last;
    do_reset();
    ready = 1'b1;
    nb    = 1'b1;
    n_out = 0;
    last  = 0;
    for (int i = 0; i < 966; i++) begin
      if ((i % 3 == 0) && (i < 960)) begin
        tick(nb, 1'b1);
        nb = ~nb;
      end else begin
        tick(1'b0, 1'b0);
      end
      if (valid === 1'b1) begin
        n_out++;
        checks++;
        if (dout !== 16'h8000) begin
          errors++;
          $display("FAIL gaps_value out#%0d got %h want 8000", n_out, dout);
        end
        checks++;
        if ((n_out == 1 && i != 577) || (n_out > 1 && i - last != 192)) begin
          errors++;
          $display("FAIL gaps_timing out#%0d got cycle %0d prev %0d", n_out, i, last);
        end
        last = i;
      end
    end
    checks++;
    if (n_out != 3) begin
      errors++;
      $display("FAIL gaps_count got %0d want 3", n_out);
    end
  endtask

  task automatic test_backpressure();
    int ovr_cnt;
    int held_bad;
    do_reset();
    ovr_cnt  = 0;
    held_bad = 0;
    for (int i = 0; i < 325; i++) begin
      ready = (i >= 323);
      tick(i < 192, i < 320);
      if (overrun === 1'b1) ovr_cnt++;
      if (i == 195) begin
        checks++;
        if (valid !== 1'b1 || dout !== 16'hFFFF) begin
          errors++;
          $display("FAIL bp_first got v=%b d=%h want v=1 d=ffff", valid, dout);
        end
      end
      if (i >= 196 && i <= 258 && (valid !== 1'b1 || dout !== 16'hFFFF)) held_bad++;
      if (i == 259) begin
        checks++;
        if (overrun !== 1'b1 || valid !== 1'b1 || dout !== 16'hD350) begin
          errors++;
          $display("FAIL bp_overwrite got o=%b v=%b d=%h want o=1 v=1 d=d350",
                   overrun, valid, dout);
        end
      end
      if (i == 260) begin
        checks++;
        if (overrun !== 1'b0) begin
          errors++;
          $display("FAIL bp_pulse_width got o=%b want 0", overrun);
        end
      end
      if (i == 323) begin
        checks++;
        if (valid !== 1'b1 || overrun !== 1'b0 || dout !== 16'h28B0) begin
          errors++;
          $display("FAIL bp_same_cycle got v=%b o=%b d=%h want v=1 o=0 d=28b0",
                   valid, overrun, dout);
        end
      end
      if (i == 324) begin
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_drain got v=%b want 0", valid);
        end
      end
    end
    checks++;
    if (held_bad != 0) begin
      errors++;
      $display("FAIL bp_hold got %0d unstable cycles want 0", held_bad);
    end
    checks++;
    if (ovr_cnt != 1) begin
      errors++;
      $display("FAIL bp_overrun_count got %0d want 1", ovr_cnt);
    end
    ready = 1'b1;
  endtask

  task automatic test_reset_midrun();
    int early;
    int first;
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 258; i++) tick(1'b1, 1'b1);
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pre got v=%b want 1", valid);
    end
    rst = 1'b1;
    tick(1'b1, 1'b1);
    rst = 1'b0;
    checks++;
    if (valid !== 1'b0 || dout !== 16'h0000 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got v=%b d=%h o=%b want v=0 d=0000 o=0", valid, dout, overrun);
    end
    ready = 1'b1;
    early = 0;
    first = -1;
    for (int j = 0; j < 198; j++) begin
      tick(1'b1, j < 192);
      if (valid === 1'b1) begin
        if (j < 195) early++;
        if (first < 0) begin
          first = j;
          checks++;
          if (dout !== 16'hFFFF) begin
            errors++;
            $display("FAIL midrun_value got %h want ffff", dout);
          end
        end
      end
    end
    checks++;
    if (early != 0 || first != 195) begin
      errors++;
      $display("FAIL midrun_settle got early=%0d first=%0d want early=0 first=195", early, first);
    end
  endtask

  // Small instance (R=2, CW=4) wraps constantly; compare with a direct [1 3 3 1] FIR.
  task automatic test_wrap_small();
    logic [2:0] q[$];
    logic [3:0] hist;
    logic [2:0] want;
    logic       b;
    logic       e;
    int         nen;
    int         nres;
    int         y;
    do_reset();
    ready = 1'b1;
    hist  = '0;
    nen   = 0;
    nres  = 0;
    for (int i = 0; i < 606; i++) begin
      b = 1'($urandom_range(0, 1));
      e = (i < 600) && ($urandom_range(0, 3) != 0);
      if (e) begin
        hist = {hist[2:0], b};
        nen++;
        if (nen % 2 == 0) begin
          nres++;
          if (nres > 2) begin
            y = int'(hist[0]) + 3 * int'(hist[1]) + 3 * int'(hist[2]) + int'(hist[3]);
            q.push_back((y > 7) ? 3'd7 : 3'(y));
          end
        end
      end
      tick(b, e);
      if (s_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL wrap_extra cycle %0d got %h want no sample", i, s_dout);
        end else begin
          want = q.pop_front();
          if (s_dout !== want) begin
            errors++;
            $display("FAIL wrap_value cycle %0d got %h want %h", i, s_dout, want);
          end
        end
      end
      if (s_overrun === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL wrap_overrun cycle %0d got 1 want 0", i);
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL wrap_missing got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    din    = 1'b0;
    din_en = 1'b0;
    ready  = 1'b1;
    test_reset();
    test_loopback(16'h4000);
    test_loopback(16'h8000);
    test_loopback(16'h0000);
    test_full_scale();
    test_enable_gaps();
    test_backpressure();
    test_reset_midrun();
    test_wrap_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fods_cic_demod.md
Name: fods_cic_demod

Overview:
- Receive side of the first-order sigma-delta link: converts a 1-bit density stream back into DATA_W-bit unsigned samples.
- Implements a sinc3 CIC decimator (3 integrators, decimate by 2^DECIM_LOG2, 3 combs), then scaling, saturation and a one-entry valid/ready output register.
- Sits after the modulator output pin (loopback) or after an external comparator; feeds DSP/UART capture logic.

Parameters:
- DATA_W, 16, output sample width; a density d maps to d*2^DATA_W.
- DECIM_LOG2, 6, log2 of the decimation ratio (default 64). Required: 3*DECIM_LOG2 >= DATA_W, DECIM_LOG2 >= 1.

Ports:
- demod_clk  input  1  sole clock; all state updates on the rising edge.
- demod_rst  input  1  synchronous, active-high reset.
- demod_din  input  1  sigma-delta bit; 1 = high density.
- demod_din_en  input  1  qualifies demod_din; 1 = consume the bit this cycle.
- demod_dout  output  DATA_W  decimated sample; held stable while demod_valid=1 and demod_ready=0.
- demod_valid  output  1  sample available.
- demod_ready  input  1  consumer accepts; a transfer occurs when valid and ready are both 1.
- demod_overrun  output  1  one-cycle pulse: an unaccepted sample was overwritten.

Behaviour:
- Clock and reset: one clock, demod_clk; reset demod_rst is synchronous and active-high.
- Reset values: integrators, combs, decimation counter and settle counter are 0; demod_dout=0, demod_valid=0, demod_overrun=0. Reset mid-operation discards everything in flight, including a pending valid sample, and restarts the settle sequence.
- Internal width: CW = 3*DECIM_LOG2+1.
  - All integrator and comb arithmetic is unsigned, modulo 2^CW.
  - Integrator wrap-around is intentional; the combs recover the exact result.
- Integrators update only when demod_din_en=1:
  - I1 += din
  - I2 += I1_new
  - I3 += I2_new
  - A chained same-edge form is allowed provided the sinc3 response is exact.
- Decimation counter (DECIM_LOG2 bits) increments on each enabled bit. On the edge where the counter wraps from 2^DECIM_LOG2-1 to 0, tick_d is registered.
- Comb pipeline, one stage per cycle after tick_d:
  - Edge T+1: C1 = I3 - I3_prev, and I3_prev <= I3.
  - Edge T+2: C2 = C1 - C1_prev.
  - Edge T+3: C3 = C2 - C2_prev.
  - Edge T+4: the output register loads.
  - Latency: demod_valid rises 4 cycles after the edge that consumed the 2^DECIM_LOG2-th bit of the period.
- Minimum decimation period of 2 enabled bits (DECIM_LOG2=1) must not collide with the pipeline. Each comb stage registers its result exactly once per tick.
- Scaling: S = C3 >> (3*DECIM_LOG2 - DATA_W). If S >= 2^DATA_W (all-ones input), demod_dout = 2^DATA_W-1 (saturate).
- Settle: the first 2 decimated results after reset are discarded because the CIC is not yet filled; a 2-bit settle counter tracks this. The 3rd and every later result are presented.
- Output handshake:
  - Load when (a new result arrives) and (valid=0 or ready=1): dout <= S, valid <= 1.
  - Load when (a new result arrives) and valid=1 and ready=0: dout <= S, valid stays 1, demod_overrun=1 for that cycle.
  - Transfer with no new result: valid <= 0 on the next edge.
  - New result in the same cycle as a transfer: the new sample loads, valid stays 1, no overrun.
- demod_din_en=0 for any duration freezes the integrators and counter; no spurious output is produced.

Decomposition:
- Shared package fods_pkg:
  - FODS_CIC_ORDER=3
  - FODS_SETTLE_DISCARD=2
  - a function computing CW from DECIM_LOG2
  - a function computing the scaling shift
- One natural sub-module: fods_cic_comb_stage, a registered differentiator with an enable and a CW-bit delay register, instantiated 3 times.

Test Plan:
- Loopback: fods_mod (DATA_W=16) with mod_din=0x4000, demod_din_en=1 continuously, ready=1 -> from the 3rd output on, demod_dout=0x4000 every 64 cycles. Repeat with mod_din=0x8000 -> 0x8000; mod_din=0x0000 -> 0x0000.
- Full scale: din=1 constantly -> steady output 0xFFFF (saturated). Then switch to din=0 -> output reaches 0x0000 within 3 decimation periods.
- Enable gaps: alternating 1/0 bits, demod_din_en toggling 1,0,0 repeating -> outputs 0x8000 every 192 cycles. Settle and latency match the cycle counts in Behaviour.
- Backpressure: ready=0 across two results -> first dout held stable, demod_overrun pulses once at the second result, dout updates. Ready and a new result in the same cycle -> no overrun, valid stays 1.
- Reset mid-run: assert demod_rst for 1 cycle with valid=1 and the comb pipeline busy -> next edge valid=0, dout=0. The first new sample appears only after 2 discarded results.
- Wrap stress: DECIM_LOG2=1 with DATA_W=3, and DECIM_LOG2=6 run for more than 2^19 bits -> outputs match a behavioural sinc3 model bit-exactly across integrator wrap-around.
